// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings for the iterative multiply/divide unit.
//               Op codes are also decoded by the controller, and the state
//               codes are also seen by the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encodings driven on muldiv_unit.op
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer state encodings. These carry an _S_ infix so they do not
    // collide with the op code MD_DIV.
    localparam logic [1:0] MD_S_IDLE = 2'd0;
    localparam logic [1:0] MD_S_MUL  = 2'd1;
    localparam logic [1:0] MD_S_DIV  = 2'd2;
    localparam logic [1:0] MD_S_FIX  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_negate
// Description : Conditional two's complement, o_y = i_en ? -i_x : i_x.
//               This module computes operand magnitudes and applies the
//               result sign fix-up.
// Ports       : i_en  - negate enable
//               i_x   - input value  (WIDTH)
//               o_y   - output value (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    assign o_y = i_en ? (~i_x + c_ONE) : i_x;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit with HI/LO registers.
//               MUL uses shift-add and retires MUL_STEP multiplier bits per
//               cycle. DIV uses restoring division and retires 1 bit per
//               cycle. Both operations work on magnitudes, and a FIX cycle
//               applies the signs and writes HI/LO.
// Ports       : clk, reset (async, active-high)
//               start/op/a/b - launch operation (accepted only in IDLE)
//               cancel       - abort in-flight operation
//               hiwe/lowe/wdata - MTHI/MTLO (IDLE only)
//               busy, done, hi, lo
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4    // must divide WIDTH and be smaller than it
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_ITERS = c_CNT_W'(WIDTH / MUL_STEP);
    localparam logic [c_CNT_W-1:0] c_DIV_ITERS = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    // These registers form a shared accumulator. In MUL, {hiAcc,loAcc} is
    // the partial product, and the multiplier shifts out of loAcc. In DIV,
    // hiAcc holds the partial remainder. The dividend shifts out of loAcc,
    // and quotient bits shift into it.
    logic [WIDTH-1:0]   r_hiAcc;
    logic [WIDTH-1:0]   r_loAcc;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand magnitude or divisor magnitude
    logic [c_CNT_W-1:0] r_count;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;

    logic               w_opSigned;
    logic               w_opDiv;
    logic               w_launch;
    logic               w_lastIter;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;

    // op[0] marks the unsigned variants, and op[1] marks the divides.
    assign w_opSigned = ~op[0];
    assign w_opDiv    = op[1];
    assign w_launch   = (r_state == MD_S_IDLE) && start && !cancel;
    assign w_lastIter = (r_count == c_CNT_ONE);

    muldiv_negate #(.WIDTH(WIDTH)) u_absA (
        .i_en (w_opSigned & a[WIDTH-1]),
        .i_x  (a),
        .o_y  (w_absA)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_absB (
        .i_en (w_opSigned & b[WIDTH-1]),
        .i_x  (b),
        .o_y  (w_absB)
    );

    // One multiplier step: add multiplicand * digit to the upper half, then
    // shift the whole product right by MUL_STEP.
    logic [WIDTH+MUL_STEP-1:0] w_mulPart;
    logic [WIDTH+MUL_STEP-1:0] w_mulSum;
    logic [2*WIDTH-1:0]        w_prodNext;

    assign w_mulPart  = {{MUL_STEP{1'b0}}, r_opnd} *
                        {{WIDTH{1'b0}}, r_loAcc[MUL_STEP-1:0]};
    assign w_mulSum   = {{MUL_STEP{1'b0}}, r_hiAcc} + w_mulPart;
    assign w_prodNext = {w_mulSum, r_loAcc[WIDTH-1:MUL_STEP]};

    // One restoring-division step. The shifted remainder needs WIDTH+1 bits,
    // because it can reach almost twice the divisor.
    logic [WIDTH:0]   w_divShift;
    logic             w_divGe;
    logic [WIDTH-1:0] w_divDiff;

    assign w_divShift = {r_hiAcc, r_loAcc[WIDTH-1]};
    assign w_divGe    = (w_divShift >= {1'b0, r_opnd});
    assign w_divDiff  = w_divShift[WIDTH-1:0] - r_opnd;

    // Sign fix-up of the results
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quotFix;
    logic [WIDTH-1:0]   w_remFix;

    muldiv_negate #(.WIDTH(2*WIDTH)) u_fixProd (
        .i_en (r_negRes),
        .i_x  ({r_hiAcc, r_loAcc}),
        .o_y  (w_prodFix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fixQuot (
        .i_en (r_negRes),
        .i_x  (r_loAcc),
        .o_y  (w_quotFix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fixRem (
        .i_en (r_negRem),
        .i_x  (r_hiAcc),
        .o_y  (w_remFix)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. A cancel in any busy state, including FIX, returns
    // to IDLE without writing HI/LO.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            MD_S_IDLE: begin
                if (w_launch) begin
                    w_stateNext = w_opDiv ? MD_S_DIV : MD_S_MUL;
                end
            end
            MD_S_MUL, MD_S_DIV: begin
                if (cancel) begin
                    w_stateNext = MD_S_IDLE;
                end else if (w_lastIter) begin
                    w_stateNext = MD_S_FIX;
                end
            end
            MD_S_FIX: begin
                w_stateNext = MD_S_IDLE;
            end
            default: begin
                w_stateNext = MD_S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_hiAcc   <= '0;
            r_loAcc   <= '0;
            r_opnd    <= '0;
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_busy <= (w_stateNext != MD_S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                MD_S_IDLE: begin
                    if (hiwe) r_hi <= wdata;
                    if (lowe) r_lo <= wdata;
                    if (w_launch) begin
                        r_hiAcc   <= '0;
                        r_opnd    <= w_opDiv ? w_absB : w_absA;
                        r_loAcc   <= w_opDiv ? w_absA : w_absB;
                        r_count   <= w_opDiv ? c_DIV_ITERS : c_MUL_ITERS;
                        r_isDiv   <= w_opDiv;
                        r_negRes  <= w_opSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_negRem  <= w_opSigned & a[WIDTH-1];
                        r_divZero <= (b == '0);
                    end
                end
                MD_S_MUL: begin
                    r_hiAcc <= w_prodNext[2*WIDTH-1:WIDTH];
                    r_loAcc <= w_prodNext[WIDTH-1:0];
                    r_count <= r_count - c_CNT_ONE;
                end
                MD_S_DIV: begin
                    r_hiAcc <= w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
                    r_loAcc <= {r_loAcc[WIDTH-2:0], w_divGe};
                    r_count <= r_count - c_CNT_ONE;
                end
                MD_S_FIX: begin
                    if (!cancel) begin
                        if (r_isDiv) begin
                            // A zero divisor produces a remainder equal to the
                            // dividend on its own. Only the quotient needs an
                            // override.
                            r_hi <= w_remFix;
                            r_lo <= r_divZero ? '1 : w_quotFix;
                        end else begin
                            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prodFix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed cases and
//               random cases are compared against an arithmetic reference
//               model, followed by directed boundary steps (MTHI/MTLO,
//               start while busy, cancel, reset mid-operation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int WIDTH      = 32;
    localparam int MUL_STEP   = 4;
    localparam int c_MUL_BUSY = WIDTH / MUL_STEP + 1;
    localparam int c_DIV_BUSY = WIDTH + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hiwe;
    logic             lowe;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hiwe   (hiwe),
        .lowe   (lowe),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: {hi, lo} computed with 64-bit arithmetic. Signed
    // division truncates toward zero, so the remainder takes the sign of the
    // dividend.
    function automatic logic [63:0] refModel(input logic [1:0] o,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            2'b00: return sx * sy;
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge, then scramble the operands to confirm the
    // DUT captured them at the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count the remaining busy cycles, then check the latency, the done pulse
    // and the results.
    task automatic waitOp(input string tag, input int already, input int expBusy,
                          input logic [63:0] expHiLo);
        int n;
        logic earlyDone;
        n = already;
        earlyDone = 1'b0;
        while (busy && n < 200) begin
            if (done) earlyDone = 1'b1;
            n++;
            tick();
        end
        check({tag, ".busyCycles"}, 64'(n), 64'(expBusy));
        check({tag, ".earlyDone"}, {63'b0, earlyDone}, 64'd0);
        check({tag, ".done"}, {63'b0, done}, 64'd1);
        check({tag, ".hi"}, {32'h0, hi}, {32'h0, expHiLo[63:32]});
        check({tag, ".lo"}, {32'h0, lo}, {32'h0, expHiLo[31:0]});
        tick();
        check({tag, ".donePulse"}, {63'b0, done}, 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] expHiLo);
        launch(o, x, y);
        waitOp(tag, 0, o[1] ? c_DIV_BUSY : c_MUL_BUSY, expHiLo);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        hiwe   = 1'b0;
        lowe   = 1'b0;
        wdata  = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst.busy", {63'b0, busy}, 64'd0);
        check("rst.done", {63'b0, done}, 64'd0);
        check("rst.hi", {32'h0, hi}, 64'd0);
        check("rst.lo", {32'h0, lo}, 64'd0);

        // Directed arithmetic cases
        runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        runOp("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        runOp("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        runOp("divu_7_2",  2'b11, 32'h0000_0007, 32'h0000_0002, {32'h0000_0001, 32'h0000_0003});
        runOp("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        runOp("divu_zero", 2'b11, 32'h0000_0005, 32'h0000_0000, {32'h0000_0005, 32'hFFFF_FFFF});
        runOp("div_zeroN", 2'b10, 32'hFFFF_FFFB, 32'h0000_0000, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        runOp("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});

        // Random cases against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) rb = 32'h0;
            else if (i % 8 == 1) rb = 32'($urandom_range(1, 15));
            else if (i % 8 == 2) rb = 32'hFFFF_FFFF;
            if (i % 8 == 3) ra = 32'h8000_0000;
            if (i % 8 == 4) ra = 32'($urandom_range(0, 100));
            runOp($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, refModel(ro, ra, rb));
        end

        // MTHI in IDLE
        hiwe  = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        hiwe = 1'b0;
        check("mthi.hi", {32'h0, hi}, 64'h1234);

        // MTLO together with start: the write lands now, and FIX overwrites it later
        lowe  = 1'b1;
        wdata = 32'h0000_55AA;
        launch(2'b01, 32'd4, 32'd5);
        lowe = 1'b0;
        check("mtloStart.lo", {32'h0, lo}, 64'h55AA);
        waitOp("mtloStart", 0, c_MUL_BUSY, {32'h0, 32'd20});

        // MTHI again, then start and hiwe while busy are both ignored
        hiwe  = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        hiwe = 1'b0;
        launch(2'b01, 32'd2, 32'd3);
        repeat (3) tick();
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd9;
        hiwe  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        hiwe  = 1'b0;
        check("ignore.hiHeld", {32'h0, hi}, 64'h1234);
        waitOp("ignore", 4, c_MUL_BUSY, {32'h0, 32'd6});

        // Cancel mid-divide: HI/LO are retained and no done pulse occurs
        launch(2'b10, 32'd100, 32'd7);
        repeat (9) tick();
        check("cancel.busyBefore", {63'b0, busy}, 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel.busy", {63'b0, busy}, 64'd0);
        check("cancel.done", {63'b0, done}, 64'd0);
        check("cancel.hi", {32'h0, hi}, 64'd0);
        check("cancel.lo", {32'h0, lo}, 64'd6);
        tick();
        check("cancel.done2", {63'b0, done}, 64'd0);

        // Cancel and start together in IDLE: start is ignored
        cancel = 1'b1;
        launch(2'b01, 32'd2, 32'd3);
        cancel = 1'b0;
        check("cancelStart.busy", {63'b0, busy}, 64'd0);
        tick();
        check("cancelStart.busy2", {63'b0, busy}, 64'd0);
        check("cancelStart.done", {63'b0, done}, 64'd0);

        // Reset mid-multiply clears everything immediately
        hiwe  = 1'b1;
        wdata = 32'h0000_ABCD;
        tick();
        hiwe = 1'b0;
        launch(2'b00, 32'd5, 32'd6);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("midRst.hi", {32'h0, hi}, 64'd0);
        check("midRst.lo", {32'h0, lo}, 64'd0);
        check("midRst.busy", {63'b0, busy}, 64'd0);
        check("midRst.done", {63'b0, done}, 64'd0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("postRst.busy", {63'b0, busy}, 64'd0);
        check("postRst.done", {63'b0, done}, 64'd0);
        check("postRst.lo", {32'h0, lo}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
